// File: rtl/sram_64x16_client_pkg.sv
// Shared types and sizes for the 64x16 SRAM request-side client.
package sram_client_pkg;
    localparam int ADDR_W    = 6;
    localparam int RSP_DEPTH = 4;
    localparam int PTR_W     = 2;
    localparam int CNT_W     = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/sram_64x16_client_if.sv
// Request/response stream bundle between a pipeline stage (master) and the SRAM client (slave).
interface sram_64x16_client_if #(
    parameter int WIDTH = 16
);
    import sram_client_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_64x16.sv
// 64x16 single-port SRAM with registered read; contents are undefined until written.
module sram_64x16
    import sram_client_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic              CLK,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  DI,
    input  logic              ENABLE,
    input  logic              WE,
    output logic [WIDTH-1:0]  DO
);
    logic [WIDTH-1:0] mem_reg [DEPTH];

    // DO holds its last read value across writes and idle cycles.
    always_ff @(posedge CLK) begin
        if (ENABLE) begin
            if (WE) begin
                mem_reg[A] <= DI;
            end else begin
                DO <= mem_reg[A];
            end
        end
    end
endmodule

// File: rtl/sram_64x16_client_rsp_fifo.sv
// Four-entry response FIFO; the head entry is presented combinationally and held until popped.
module sram_rsp_fifo
    import sram_client_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [RSP_DEPTH-1:0][WIDTH-1:0] entries;

    genvar gi;
    generate
        for (gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign entries[gi] = data_reg;
        end
    endgenerate

    // Pointers are exactly PTR_W bits wide so they wrap modulo the depth for free.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head  = entries[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/sram_64x16_client.sv
// Request-side controller for a 64x16 registered-read SRAM: zero-fills after reset,
// then forwards requests and returns read data through a credit-limited response FIFO.
module sram_64x16_client
    import sram_client_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                CLK,
    input  logic                RST,
    sram_64x16_client_if.slave  bus,
    output logic                init_done,
    output logic [ADDR_W-1:0]   A,
    output logic [WIDTH-1:0]    DI,
    output logic                ENABLE,
    output logic                WE,
    input  logic [WIDTH-1:0]    DO
);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W + 1)'(RSP_DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              inflight_reg, inflight_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    outstanding;
    logic              credit_ok;
    logic              req_ready;
    logic              read_accept;
    logic              pop;
    logic [WIDTH-1:0]  head;

    // Credit counts both queued responses and the read whose DO arrives next cycle,
    // so a push can never find the FIFO full.
    assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign credit_ok   = (outstanding < CREDIT_LIMIT);
    assign read_accept = bus.req_valid & req_ready & ~bus.req_write;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        inflight_next = read_accept;
        init_done     = 1'b0;
        req_ready     = 1'b0;
        ENABLE        = 1'b0;
        WE            = 1'b0;
        A             = bus.req_addr;
        DI            = bus.req_wdata;
        case (state_reg)
            INIT: begin
                ENABLE   = 1'b1;
                WE       = 1'b1;
                A        = cnt_reg;
                DI       = '0;
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == LAST_ADDR) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                init_done = 1'b1;
                req_ready = credit_ok;
                ENABLE    = bus.req_valid & credit_ok;
                WE        = bus.req_write;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= INIT;
            cnt_reg      <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            inflight_reg <= inflight_next;
        end
    end

    assign pop = bus.rsp_valid & bus.rsp_ready;

    sram_rsp_fifo #(
        .WIDTH (WIDTH)
    ) u_rsp_fifo (
        .clk       (CLK),
        .srst      (RST),
        .push      (inflight_reg),
        .push_data (DO),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_data  = head;
endmodule

// File: doc/sram_64x16_client.md
# sram_64x16_client

Request-side controller for the 64x16 registered-read single-port SRAM. It accepts read/write requests on a valid/ready stream and drives the SRAM's `A`/`DI`/`ENABLE`/`WE` pins. It captures `DO` one cycle after each read and returns read data on a buffered valid/ready response stream. After reset it zero-fills the whole SRAM before accepting traffic. It sits between the MPEG4 pipeline stages and each SRAM instance.

## Interface
Parameters:
- `WIDTH`, 16, data width; must match the SRAM.
- `DEPTH`, 64, word count; address width is 6.

Ports:
- `CLK`  in  1  rising-edge clock shared with the SRAM.
- `RST`  in  1  reset, **synchronous, active-high**.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  6  word address.
- `req_wdata`  in  WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes data when `rsp_valid & rsp_ready`.
- `rsp_data`  out  WIDTH  read data, in request order.
- `init_done`  out  1  high once the zero-fill completes.
- `A`  out  6  SRAM address.
- `DI`  out  WIDTH  SRAM write data.
- `ENABLE`  out  1  SRAM enable.
- `WE`  out  1  SRAM write enable.
- `DO`  in  WIDTH  SRAM registered read data.

## Operation
- State machine with two states, `INIT` and `RUN`. Reset state is `INIT`.
- `INIT` state:
  - Init counter runs 0..63.
  - Each cycle drives `ENABLE=1`, `WE=1`, `A=counter`, `DI=0`.
  - `req_ready=0`.
  - After address 63 is written, the next state is `RUN`.
- `RUN` state:
  - `init_done=1`.
  - `ENABLE = req_valid & req_ready`.
  - `WE = req_write`, `A = req_addr`, `DI = req_wdata`. These are combinational pass-through.
- Writes produce no response.
- Reads:
  - An accepted read sets the in-flight flag.
  - In the next cycle, `DO` is pushed into a 4-entry response FIFO and the flag clears, unless a new read is accepted in that same cycle.
- Credit rule: `req_ready = RUN & (fifo_count + inflight < 4)`.
  - Computed from registered state only; it has no dependence on `req_valid` or `rsp_ready`.
  - It applies to writes as well as reads.
- FIFO:
  - Head drives `rsp_data`. `rsp_valid = (fifo_count != 0)`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers are 2 bits and wrap modulo 4. `fifo_count` is 3 bits, range 0..4.
- Simultaneous read accept and `DO` capture are legal. This is the normal back-to-back case.
- Read-after-write to the same address in consecutive cycles returns the new data. The SRAM orders these accesses itself; no forwarding is required.

## Timing
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `init_done=0`.
  - `ENABLE=1`, `WE=1`, `A=0`, `DI=0` (first INIT cycle).
  - FIFO empty, in-flight flag 0, counter 0.
- `RST` in the middle of operation:
  - Discards the in-flight read and all FIFO contents.
  - Restarts the zero-fill.
- Init duration: 64 cycles. `init_done` and `req_ready` rise in cycle 64 after reset deasserts.
- Read latency:
  - Read accepted in cycle t.
  - `DO` valid in t+1 and pushed at the end of t+1.
  - `rsp_valid=1` in t+2.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Backpressure: when `rsp_ready=0`, at most 4 reads are outstanding (FIFO entries plus in-flight). `req_ready` deasserts when the total reaches 4.
- `rsp_data` and `rsp_valid` are stable while `rsp_valid & !rsp_ready`.

## Structure
- Shared package `sram_client_pkg`:
  - `ADDR_W = 6`.
  - `RSP_DEPTH = 4`.
  - State enum `{INIT, RUN}`.
- Sub-module `sram_rsp_fifo`: 4 x WIDTH synchronous FIFO with count output.
- The top level holds the state machine, init counter, in-flight flag, credit logic and SRAM muxing.
- The bench instantiates the real 64x16 SRAM model against this block.

## Test plan
- **Init:** deassert `RST`, then read all 64 addresses.
  - `init_done` rises at cycle 64.
  - Every `rsp_data = 0`.
- **Write then read:** write 0xBEEF@5, then read @5 in the next cycle.
  - `rsp_data = 0xBEEF`, `rsp_valid` two cycles after the read is accepted.
- **Streaming:** addresses 0..15 preloaded with `16'h1000+i`; issue 16 back-to-back reads with `rsp_ready=1`.
  - `req_ready` never drops.
  - Responses arrive in order, one per cycle.
- **Backpressure:** hold `rsp_ready=0` and issue reads continuously.
  - Exactly 4 accepted, then `req_ready=0`.
  - Raising `rsp_ready` drains in order and re-enables requests.
- **Mid-operation reset:** assert `RST` with 3 reads outstanding.
  - `rsp_valid=0` the next cycle.
  - INIT restarts and previously written data reads back as 0.
- **Wrap-around:** drive 10 fill/drain cycles with random `rsp_ready`.
  - FIFO pointers wrap.
  - Data matches a scoreboard and no response is lost or duplicated.
